// File: rtl/ctrl_regfile.sv
// Control register file: CONTROL/PROGBANK/KEY/STATUS registers, a two-key unlock
// sequence guarding the flash program bank, and the boot overlay (OVL) flag.
module ctrl_regfile #(
  parameter int          BANK_W      = 2,
  parameter int          OVL_TIMEOUT = 0,
  parameter logic [15:0] KEY1        = 16'hA5C3,
  parameter logic [15:0] KEY2        = 16'h5A3C,
  parameter logic [1:0]  Z2_DATA     = 2'd2
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              AS_n,
  input  logic              RW,
  input  logic [23:16]      ADDR,
  input  logic [1:0]        REG_SEL,
  input  logic [15:0]       DIN,
  input  logic              ctrl_access,
  input  logic [1:0]        z2_state,
  input  logic              flash_enabled,
  input  logic [BANK_W-1:0] flash_bank,
  output logic [15:0]       DOUT,
  output logic              dtack,
  output logic              flash_a18,
  output logic [BANK_W-1:0] flash_ahi,
  output logic              OVL,
  output logic              mapram_en,
  output logic              otherram_en,
  output logic [1:0]        unlock_state_o
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_KEY_OK   = 2'd1,
    ST_UNLOCKED = 2'd2
  } unlock_state_e;

  localparam logic [1:0] SEL_CONTROL  = 2'd0;
  localparam logic [1:0] SEL_PROGBANK = 2'd1;
  localparam logic [1:0] SEL_KEY      = 2'd2;

  localparam int CNT_W = (OVL_TIMEOUT > 1) ? $clog2(OVL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (OVL_TIMEOUT > 0) ? CNT_W'(OVL_TIMEOUT - 1) : '0;

  unlock_state_e     state_q, state_d;
  logic              ovl_q, ovl_d;
  logic              mapram_q, mapram_d;
  logic              other_q, other_d;
  logic [BANK_W-1:0] progbank_q, progbank_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic wr;
  logic cia_wr;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= ST_LOCKED;
      ovl_q      <= 1'b1;
      mapram_q   <= 1'b0;
      other_q    <= 1'b0;
      progbank_q <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ovl_q      <= ovl_d;
      mapram_q   <= mapram_d;
      other_q    <= other_d;
      progbank_q <= progbank_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  // done latches the acceptance so a long strobe is serviced exactly once.
  always_comb begin
    accept     = (z2_state == Z2_DATA) && ctrl_access && !done_q;
    wr         = accept && !RW;
    cia_wr     = (ADDR == 8'hBF) && !RW && !AS_n;
    done_d     = done_q;
    mapram_d   = mapram_q;
    other_d    = other_q;
    progbank_d = progbank_q;
    ovl_d      = ovl_q;
    cnt_d      = cnt_q;
    state_d    = state_q;

    if (accept) begin
      done_d = 1'b1;
    end else if (AS_n) begin
      done_d = 1'b0;
    end

    if (wr) begin
      case (REG_SEL)
        SEL_CONTROL: begin
          if (DIN[0]) begin
            mapram_d = mapram_q | DIN[2];
            other_d  = other_q | DIN[1];
          end else if (DIN[1]) begin
            other_d = 1'b0;
          end
        end
        SEL_PROGBANK: begin
          if (state_q == ST_UNLOCKED) begin
            progbank_d = DIN[BANK_W-1:0];
            state_d    = ST_LOCKED;
          end
        end
        SEL_KEY: begin
          case (state_q)
            ST_LOCKED:   state_d = (DIN == KEY1) ? ST_KEY_OK : ST_LOCKED;
            ST_KEY_OK: begin
              if (DIN == KEY2)      state_d = ST_UNLOCKED;
              else if (DIN == KEY1) state_d = ST_KEY_OK;
              else                  state_d = ST_LOCKED;
            end
            default:     state_d = ST_LOCKED;
          endcase
        end
        default: ;
      endcase
    end

    // Overlay drops on a CIA write or after the optional timeout, whichever first.
    if (cia_wr) ovl_d = 1'b0;
    if ((OVL_TIMEOUT != 0) && ovl_q) begin
      if (cnt_q == CNT_LAST) ovl_d = 1'b0;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    DOUT = 16'h0000;
    case (REG_SEL)
      2'd0:    DOUT = {13'b0, mapram_q, other_q, 1'b0};
      2'd1:    DOUT = {{(16-BANK_W){1'b0}}, progbank_q};
      2'd2:    DOUT = 16'h0000;
      default: DOUT = {{(8-BANK_W){1'b0}}, flash_bank, 4'b0,
                       (state_q == ST_UNLOCKED), flash_enabled, other_q, mapram_q};
    endcase
  end

  assign dtack          = done_q;
  assign flash_ahi      = (flash_enabled && !mapram_q) ? flash_bank : progbank_q;
  assign flash_a18      = (ovl_q && !ADDR[23]) ? 1'b1 : ADDR[19];
  assign OVL            = ovl_q;
  assign mapram_en      = mapram_q;
  assign otherram_en    = other_q;
  assign unlock_state_o = state_q;

endmodule

// File: tb/tb_ctrl_regfile.sv
// Bench for ctrl_regfile: directed steps for reset, overlay timing and unlock
// sequence, then randomized register accesses against a behavioural model.
module tb_ctrl_regfile;

  localparam logic [1:0]  Z2_DATA = 2'd2;
  localparam logic [1:0]  Z2_IDLE = 2'd0;
  localparam logic [15:0] K1      = 16'hA5C3;
  localparam logic [15:0] K2      = 16'h5A3C;

  logic        CLK;
  logic        RESET_n;
  logic        AS_n;
  logic        RW;
  logic [23:16] ADDR;
  logic [1:0]  REG_SEL;
  logic [15:0] DIN;
  logic        ctrl_access;
  logic [1:0]  z2_state;
  logic        flash_enabled;
  logic [1:0]  flash_bank;
  logic [15:0] DOUT;
  logic        dtack;
  logic        flash_a18;
  logic [1:0]  flash_ahi;
  logic        OVL;
  logic        mapram_en;
  logic        otherram_en;
  logic [1:0]  unlock_state;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: keys_seen counts progress through the two-key sequence.
  logic       m_map;
  logic       m_oth;
  logic [1:0] m_pb;
  int         keys_seen;

  ctrl_regfile #(
    .BANK_W(2), .OVL_TIMEOUT(8), .KEY1(K1), .KEY2(K2), .Z2_DATA(Z2_DATA)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .AS_n(AS_n), .RW(RW), .ADDR(ADDR),
    .REG_SEL(REG_SEL), .DIN(DIN), .ctrl_access(ctrl_access), .z2_state(z2_state),
    .flash_enabled(flash_enabled), .flash_bank(flash_bank), .DOUT(DOUT),
    .dtack(dtack), .flash_a18(flash_a18), .flash_ahi(flash_ahi), .OVL(OVL),
    .mapram_en(mapram_en), .otherram_en(otherram_en), .unlock_state_o(unlock_state)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus;
    AS_n        = 1'b1;
    RW          = 1'b1;
    ctrl_access = 1'b0;
    z2_state    = Z2_IDLE;
  endtask

  task automatic model_reset;
    m_map     = 1'b0;
    m_oth     = 1'b0;
    m_pb      = 2'd0;
    keys_seen = 0;
  endtask

  task automatic model_write(input logic [1:0] sel, input logic [15:0] din);
    if (sel == 2'd0) begin
      if (din[0]) begin
        if (din[2]) m_map = 1'b1;
        if (din[1]) m_oth = 1'b1;
      end else if (din[1]) begin
        m_oth = 1'b0;
      end
    end else if (sel == 2'd1) begin
      if (keys_seen == 2) begin
        m_pb      = din[1:0];
        keys_seen = 0;
      end
    end else if (sel == 2'd2) begin
      if (keys_seen == 2)                       keys_seen = 0;
      else if (din == K1)                       keys_seen = 1;
      else if (keys_seen == 1 && din == K2)     keys_seen = 2;
      else                                      keys_seen = 0;
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return {13'b0, m_map, m_oth, 1'b0};
      2'd1:    return {14'b0, m_pb};
      2'd2:    return 16'h0000;
      default: return {6'b0, flash_bank, 4'b0, (keys_seen == 2), flash_enabled, m_oth, m_map};
    endcase
  endfunction

  function automatic logic [1:0] exp_ahi();
    return (flash_enabled && !m_map) ? flash_bank : m_pb;
  endfunction

  task automatic access(input logic rw, input logic [1:0] sel, input logic [15:0] din);
    AS_n = 1'b0; RW = rw; REG_SEL = sel; DIN = din;
    ctrl_access = 1'b1; z2_state = Z2_DATA;
    tick;
    check("dtack_accept", dtack, 1'b1);
    if (rw) check("read_data", DOUT, exp_read(sel));
    else    model_write(sel, din);
    check("mapram", mapram_en, m_map);
    check("otherram", otherram_en, m_oth);
    check("flash_ahi", flash_ahi, exp_ahi());
    idle_bus;
    tick;
    check("dtack_release", dtack, 1'b0);
  endtask

  task automatic do_reset;
    idle_bus;
    RESET_n = 1'b0;
    model_reset();
    #2;
    check("rst_ovl", OVL, 1'b1);
    check("rst_dtack", dtack, 1'b0);
    check("rst_mapram", mapram_en, 1'b0);
    check("rst_otherram", otherram_en, 1'b0);
    @(negedge CLK);
    RESET_n = 1'b1;
  endtask

  initial begin
    logic [1:0]  sel;
    logic [15:0] din;
    logic        rw;
    RESET_n = 1'b1; ADDR = 8'h00; REG_SEL = 2'd1; DIN = 16'h0000;
    flash_enabled = 1'b0; flash_bank = 2'd0;
    idle_bus;
    #1;

    // Reset state and overlay timeout with ADDR 00
    do_reset();
    check("rst_progbank_read", DOUT, 16'h0000);
    check("rst_flash_ahi", flash_ahi, 2'd0);
    for (int i = 1; i <= 7; i++) begin
      tick;
      check("ovl_before_timeout", OVL, 1'b1);
      check("a18_overlay", flash_a18, 1'b1);
    end
    tick;
    check("ovl_timeout", OVL, 1'b0);
    check("a18_after_timeout", flash_a18, 1'b0);
    ADDR = 8'h08;
    #1;
    check("a18_addr19", flash_a18, 1'b1);
    ADDR = 8'h00;

    // Broken key sequence leaves the program bank untouched
    access(1'b0, 2'd2, K1);
    access(1'b0, 2'd2, 16'h1234);
    access(1'b0, 2'd1, 16'h0003);
    access(1'b1, 2'd1, 16'h0000);
    check("progbank_locked", DOUT, 16'h0000);

    // Long strobe: CONTROL write accepted once, dtack held
    AS_n = 1'b0; RW = 1'b0; REG_SEL = 2'd0; DIN = 16'h0005;
    ctrl_access = 1'b1; z2_state = Z2_DATA;
    model_write(2'd0, 16'h0005);
    for (int i = 0; i < 6; i++) begin
      tick;
      check("dtack_hold", dtack, 1'b1);
    end
    check("hold_mapram", mapram_en, 1'b1);
    idle_bus;
    tick;
    check("hold_release", dtack, 1'b0);

    // Held KEY2 must advance the unlock sequence once, not relock it
    access(1'b0, 2'd2, K1);
    AS_n = 1'b0; RW = 1'b0; REG_SEL = 2'd2; DIN = K2;
    ctrl_access = 1'b1; z2_state = Z2_DATA;
    model_write(2'd2, K2);
    for (int i = 0; i < 6; i++) tick;
    idle_bus;
    tick;
    access(1'b1, 2'd3, 16'h0000);
    check("held_key_unlocked", DOUT[3], 1'b1);
    access(1'b0, 2'd1, 16'h0002);

    // otherram set then cleared, mapram sticky
    access(1'b0, 2'd0, 16'h0003);
    access(1'b0, 2'd0, 16'h0002);
    check("oth_cleared", otherram_en, 1'b0);
    check("map_sticky", mapram_en, 1'b1);

    // Full unlock then program bank 3 with mapram set
    flash_enabled = 1'b1; flash_bank = 2'd1;
    access(1'b0, 2'd2, K1);
    access(1'b0, 2'd2, K2);
    access(1'b0, 2'd1, 16'h0003);
    check("ahi_progbank", flash_ahi, 2'b11);
    access(1'b1, 2'd3, 16'h0000);
    check("status_relocked", DOUT[3], 1'b0);
    access(1'b0, 2'd3, 16'hFFFF);
    access(1'b1, 2'd0, 16'h0000);

    // CIA write clears OVL early
    do_reset();
    tick; tick;
    check("ovl_pre_cia", OVL, 1'b1);
    ADDR = 8'hBF; RW = 1'b0; AS_n = 1'b0;
    tick;
    check("ovl_cia", OVL, 1'b0);
    idle_bus; ADDR = 8'h00;
    tick;
    check("ovl_stays_low", OVL, 1'b0);
    check("cia_a18", flash_a18, 1'b0);

    // CIA write on the timeout edge
    do_reset();
    for (int i = 0; i < 7; i++) tick;
    check("ovl_edge7", OVL, 1'b1);
    ADDR = 8'hBF; RW = 1'b0; AS_n = 1'b0;
    tick;
    check("ovl_same_edge", OVL, 1'b0);
    check("same_edge_map", mapram_en, 1'b0);
    check("same_edge_oth", otherram_en, 1'b0);
    check("same_edge_dtack", dtack, 1'b0);
    idle_bus; ADDR = 8'h00;
    tick;

    // Reset mid-access, then re-accept only when the data phase returns
    AS_n = 1'b0; RW = 1'b0; REG_SEL = 2'd0; DIN = 16'h0007;
    ctrl_access = 1'b1; z2_state = Z2_DATA;
    tick;
    check("mid_dtack", dtack, 1'b1);
    check("mid_map", mapram_en, 1'b1);
    RESET_n = 1'b0;
    model_reset();
    #1;
    check("async_dtack", dtack, 1'b0);
    check("async_ovl", OVL, 1'b1);
    check("async_map", mapram_en, 1'b0);
    z2_state = Z2_IDLE;
    @(negedge CLK);
    RESET_n = 1'b1;
    tick;
    check("no_accept_idle", dtack, 1'b0);
    check("no_write_idle", mapram_en, 1'b0);
    z2_state = Z2_DATA;
    model_write(2'd0, 16'h0007);
    tick;
    check("reaccept_dtack", dtack, 1'b1);
    check("reaccept_map", mapram_en, m_map);
    check("reaccept_oth", otherram_en, m_oth);
    idle_bus;
    for (int i = 0; i < 10; i++) tick;
    check("ovl_settled", OVL, 1'b0);

    // Randomized accesses against the model
    for (int n = 0; n < 150; n++) begin
      flash_enabled = 1'($urandom_range(0, 1));
      flash_bank    = 2'($urandom_range(0, 3));
      ADDR          = 8'($urandom_range(0, 255));
      sel           = 2'($urandom_range(0, 3));
      rw            = 1'($urandom_range(0, 1));
      if (sel == 2'd0)      din = 16'($urandom_range(0, 7));
      else if (sel == 2'd2) begin
        case ($urandom_range(0, 3))
          0:       din = K1;
          1:       din = K2;
          default: din = 16'($urandom);
        endcase
      end else din = 16'($urandom);
      access(rw, sel, din);
      check("rand_a18", flash_a18, ADDR[19]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_regfile.md
CTRL_REGFILE -- requirements
Module: ctrl_regfile

Parameters
REQ-001 The block SHALL have parameter BANK_W, default 2, giving the flash bank select width (2**BANK_W banks, 512 KB each).
REQ-002 The block SHALL have parameter OVL_TIMEOUT, default 0, giving the cycle count after which OVL self-clears (0 = disabled).
REQ-003 The block SHALL have parameter KEY1, default 16'hA5C3, the first unlock key.
REQ-004 The block SHALL have parameter KEY2, default 16'h5A3C, the second unlock key.

Interface
REQ-005 The block SHALL have input CLK, 1 bit, the system clock; all state updates on its rising edge.
REQ-006 The block SHALL have input RESET_n, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have input AS_n, 1 bit, the bus address strobe, active-low.
REQ-008 The block SHALL have input RW, 1 bit: 1 = read, 0 = write.
REQ-009 The block SHALL have input ADDR[23:16], 8 bits, the upper bus address.
REQ-010 The block SHALL have input REG_SEL, 2 bits, the register index (from A[2:1]).
REQ-011 The block SHALL have input DIN, 16 bits, the write data.
REQ-012 The block SHALL have input ctrl_access, 1 bit, the decoded control space select.
REQ-013 The block SHALL have input z2_state, 2 bits, the Zorro II bus phase; Z2_DATA comes from globalparams.vh.
REQ-014 The block SHALL have inputs flash_enabled (1 bit) and flash_bank (BANK_W bits), the runtime-selected boot bank.
REQ-015 The block SHALL have output DOUT, 16 bits, the read data.
REQ-016 The block SHALL have output dtack, 1 bit, the access acknowledge.
REQ-017 The block SHALL have output flash_a18, 1 bit.
REQ-018 The block SHALL have output flash_ahi, BANK_W bits, driving flash A[18+BANK_W:19].
REQ-019 The block SHALL have registered outputs OVL, mapram_en and otherram_en, 1 bit each.

Function
REQ-020 An access SHALL be accepted when z2_state == Z2_DATA, ctrl_access = 1 and done = 0.
REQ-021 On acceptance, done SHALL be set on the same edge; dtack = done (one-cycle latency).
REQ-022 done SHALL clear on the first edge with AS_n = 1, so each bus cycle is accepted exactly once; a write never repeats within one AS_n assertion.
REQ-023 REG_SEL 0 (CONTROL), write: DIN[0] = 1 ORs DIN[2:1] into {mapram_en, otherram_en}; DIN[0] = 0 clears otherram_en where DIN[1] = 1; mapram_en is never cleared except by reset.
REQ-024 REG_SEL 1 (PROGBANK), write: flash_progbank <= DIN[BANK_W-1:0] only in state UNLOCKED, and the FSM then returns to LOCKED; when not UNLOCKED the write is ignored but still acknowledged.
REQ-025 REG_SEL 2 (KEY), unlock FSM: LOCKED -KEY1-> KEY_OK; KEY_OK -KEY2-> UNLOCKED; KEY_OK with any other value -> LOCKED; UNLOCKED with any KEY write -> LOCKED; KEY1 received in KEY_OK stays KEY_OK.
REQ-026 REG_SEL 3 (STATUS) SHALL be read-only; writes to it are acknowledged with no effect.
REQ-027 Read data, combinational: STATUS = {flash_bank zero-extended to 8 bits, 4'b0, unlocked, flash_enabled, otherram_en, mapram_en}; CONTROL = {13'b0, mapram_en, otherram_en, 1'b0}; PROGBANK = flash_progbank zero-extended; KEY = 16'h0.
REQ-028 flash_ahi = (flash_enabled && !mapram_en) ? flash_bank : flash_progbank.
REQ-029 flash_a18 = (OVL && !ADDR[23]) ? 1 : ADDR[19].
REQ-030 OVL SHALL clear on any edge with ADDR[23:16] == 8'hBF, RW = 0 and AS_n = 0.
REQ-031 When OVL_TIMEOUT != 0, a counter sized for OVL_TIMEOUT increments while OVL = 1; OVL clears when the counter reaches OVL_TIMEOUT-1, and the counter holds thereafter (no wrap).
REQ-032 When a CIA write and the timeout occur on the same edge, OVL clears once, with no other effect.
REQ-033 No write effect SHALL occur while RW = 1.

Reset
REQ-034 While RESET_n = 0, the block SHALL hold OVL = 1, mapram_en = 0, otherram_en = 0, flash_progbank = 0, done = 0, FSM = LOCKED and counter = 0, regardless of CLK.
REQ-035 Reset asserted mid-access SHALL drop dtack immediately; after release, a still-asserted AS_n is accepted anew only once z2_state returns to Z2_DATA.

Verification
REQ-036 Write KEY 16'hA5C3, KEY 16'h5A3C, then PROGBANK 16'h0003, with mapram_en = 1 -> flash_ahi = 2'b11; STATUS bit3 = 0 afterward.
REQ-037 Write KEY 16'hA5C3, KEY 16'h1234, then PROGBANK 3 -> flash_progbank stays 0; dtack is still asserted for each write.
REQ-038 Hold z2_state = Z2_DATA and AS_n = 0 for 6 cycles, writing CONTROL 16'h0005 -> dtack is high from cycle 2 on; one accept only; mapram_en = 1.
REQ-039 Write CONTROL 16'h0002 after mapram set -> otherram_en = 0 and mapram_en stays 1.
REQ-040 OVL_TIMEOUT = 8, no CIA write -> OVL falls after exactly 8 cycles post-reset; ADDR 8'h00 gives flash_a18 = 1 before, ADDR[19] after.
REQ-041 Pulse RESET_n low mid-write with dtack = 1 -> dtack = 0 and OVL = 1 asynchronously.
